fetch_redirect_unit: RTL
========================

# fetch_redirect_unit

Instruction-fetch stage of the 5-stage pipelined CPU: owns the PC register and the IF/ID pipeline register. It consumes the branch decision made in ID by the branch comparator (`Branch_flag`), plus the jump/jump-register controls, and redirects fetch accordingly. On a redirect it either squashes the wrong-path instruction or keeps it as a delay slot, selected at compile time. It also honours load-use stalls from the hazard unit.

## Interface
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard-unit hold; PC and IF/ID keep their contents.
- `Branch_flag` in 1: branch-taken decision for the instruction in ID.
- `Jump` in 1: j/jal in ID.
- `JumpReg` in 1: jr/jalr in ID.
- `branch_target` in 32: PC_plus4_ID + (sign-extended imm << 2), computed in ID.
- `jump_index` in 26: instr_index field of the ID instruction.
- `busA` in 32: forwarded rs value for jr/jalr.
- `imem_data` in 32: instruction word at `imem_addr`; combinational read, same cycle.
- `imem_addr` out 32: current PC.
- `instr_ID` out 32: IF/ID instruction.
- `PC_plus4_ID` out 32: IF/ID PC+4.
- `valid_ID` out 1: IF/ID holds a real instruction.
- `redirect_count` out 32: number of honoured redirects.

## Operation
- Registered state: `PC`, `instr_ID`, `PC_plus4_ID`, `valid_ID`, `redirect_count`, and the FSM state.
- FSM states: FILL and RUN. Reset enters FILL. FILL moves to RUN after one non-stalled cycle. In FILL, redirect inputs are ignored, because ID holds a bubble.
- A redirect is honoured only when all hold: state is RUN, `valid_ID`=1, `stall`=0, and at least one of `JumpReg`/`Jump`/`Branch_flag` is asserted.
- Priority per edge, highest first:
  1. `reset`
  2. `stall`: hold everything, ignore all redirect inputs. The branch operands are stale while stalled.
  3. `JumpReg`: next PC = {`busA[31:2]`, 2'b00}.
  4. `Jump`: next PC = {`PC_plus4_ID[31:28]`, `jump_index`, 2'b00}.
  5. `Branch_flag`: next PC = {`branch_target[31:2]`, 2'b00}.
  6. Otherwise next PC = PC + 4, with 32-bit wrap (32'hFFFF_FFFC wraps to 32'h0).
- IF/ID load on a non-stalled edge: `instr_ID` ← `imem_data`, `PC_plus4_ID` ← PC+4, `valid_ID` ← 1.
- Squash on an honoured redirect (macro off only): `instr_ID` ← 32'h0 (nop), `valid_ID` ← 0. `PC_plus4_ID` still loads PC+4.
- `redirect_count`: +1 per honoured redirect, wraps modulo 2^32. A held or ignored redirect never counts.
- PC bits [1:0] are always 0.

## Timing
- Reset values: PC = `RESET_PC`, `imem_addr` = `RESET_PC`, `instr_ID` = 0, `PC_plus4_ID` = 0, `valid_ID` = 0, `redirect_count` = 0, state = FILL.
- Reset mid-operation: all of the above is restored on the same edge; any pending redirect is discarded.
- Redirect latency: decision in ID during cycle n; `imem_addr` equals the target in cycle n+1.
- The instruction fetched in cycle n is the single post-branch slot: squashed or kept per the macro.
- Stall and redirect asserted in the same cycle: the stall wins. The redirect takes effect on the first unstalled cycle, provided the inputs are still asserted then.
- Back-to-back redirects: the second is impossible when squashing, since ID holds a bubble. With delay slots, a redirect from the slot instruction is honoured normally.

## Configuration
- `DELAY_SLOT_EN` defined: no squash. The post-branch instruction enters ID with `valid_ID`=1 (MIPS delay-slot semantics).
- `DELAY_SLOT_EN` undefined: that instruction is squashed to a bubble, giving a 1-cycle taken-branch penalty.
- Redirect target computation and `redirect_count` behave identically in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - `RESET_PC` default
  - `NOP_INSTR` = 32'h0
  - the FSM state enum (FILL, RUN)
- One sub-module, `next_pc_sel`: combinational priority mux and target formation. It takes PC, the redirect controls, the targets, and `PC_plus4_ID`, and returns next PC and a `redirect` strobe.
- Registers, FSM and counter live in the top level.

## Test plan
- Reset, then 3 idle cycles: `imem_addr` goes 3000 → 3004 → 3008 → 300C. `valid_ID` is 0 for the first cycle after reset, then 1.
- Branch_flag=1, valid_ID=1, `branch_target`=32'h0000_3040: next cycle `imem_addr`=3040, `redirect_count`=1. Without the macro, the following `valid_ID`=0 and `instr_ID`=0. With the macro, the slot instruction has `valid_ID`=1.
- JumpReg=1, Jump=1, Branch_flag=1 together, `busA`=32'h0000_3103: target 3100 (JumpReg wins, low bits cleared).
- Jump=1 with `stall`=1 for 2 cycles, then `stall`=0: PC and IF/ID are frozen for 2 cycles. The redirect occurs on the 3rd cycle and `redirect_count` increments once.
- PC=32'hFFFF_FFFC with no redirect: next PC=32'h0.
- `reset` asserted the same cycle as Branch_flag: PC=3000, `redirect_count`=0, state FILL.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and FSM state encoding.
package cpu_pkg;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: jr/jalr over j/jal over taken branch over sequential PC+4.
// Latency: purely combinational, result consumed on the same edge.
// Backpressure: none here; stall gating is applied by the caller.
module next_pc_sel (
    input  logic [31:0] pc,
    input  logic        enable,
    input  logic        jump_reg,
    input  logic        jump,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] bus_a,
    input  logic [31:0] pc_plus4_id,
    output logic [31:0] next_pc,
    output logic        redirect
);
    // Low target bits are forced to zero so PC stays word aligned.
    logic unused_bits;
    assign unused_bits = ^{bus_a[1:0], branch_target[1:0], pc_plus4_id[27:0]};

    always_comb begin
        next_pc  = pc + 32'd4;
        redirect = enable & (jump_reg | jump | branch_flag);
        if (enable) begin
            if (jump_reg)
                next_pc = {bus_a[31:2], 2'b00};
            else if (jump)
                next_pc = {pc_plus4_id[31:28], jump_index, 2'b00};
            else if (branch_flag)
                next_pc = {branch_target[31:2], 2'b00};
        end
    end
endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch stage: PC register, IF/ID register and redirect handling; DELAY_SLOT_EN keeps the post-branch slot instead of squashing it.
// Latency: a redirect decided in ID during cycle n drives imem_addr with the target in cycle n+1.
// Backpressure: stall freezes PC, IF/ID, FSM and counter; redirects are only honoured on unstalled cycles.
module fetch_redirect_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Branch_flag,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] busA,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] instr_ID,
    output logic [31:0] PC_plus4_ID,
    output logic        valid_ID,
    output logic [31:0] redirect_count
);
    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         redirect;

    assign imem_addr = pc;

    // ID holds a bubble in FILL or after a squash, so its controls are meaningless then.
    next_pc_sel u_next_pc_sel (
        .pc            (pc),
        .enable        ((state == RUN) && valid_ID),
        .jump_reg      (JumpReg),
        .jump          (Jump),
        .branch_flag   (Branch_flag),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .bus_a         (busA),
        .pc_plus4_id   (PC_plus4_ID),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FILL;
            pc             <= RESET_PC;
            instr_ID       <= NOP_INSTR;
            PC_plus4_ID    <= 32'h0;
            valid_ID       <= 1'b0;
            redirect_count <= 32'h0;
        end else if (!stall) begin
            state       <= RUN;
            pc          <= next_pc;
            PC_plus4_ID <= pc + 32'd4;
`ifdef DELAY_SLOT_EN
            instr_ID    <= imem_data;
            valid_ID    <= 1'b1;
`else
            instr_ID    <= redirect ? NOP_INSTR : imem_data;
            valid_ID    <= !redirect;
`endif
            if (redirect)
                redirect_count <= redirect_count + 32'd1;
        end
    end
endmodule
